addsub32_seq: RTL

Sequencer that computes 32-bit add/subtract by time-multiplexing one 16-bit carry-lookahead add/subtract datapath over two cycles: low half first, high half second, with the low-half carry chained into the high half. It sits between the ALU issue logic and the shared 16-bit adder. It configures the adder for subtraction by inverting B and forcing carry-in. It uses a valid/ready handshake on both sides so multi-cycle ALU ops can stall the pipeline cleanly.

---
 rtl/addsub32_seq_pkg.sv | 9 +
 rtl/adder_subtractor_16bits.sv | 10 +
 rtl/addsub32_seq.sv | 79 +++++++
 3 files changed

// File: rtl/addsub32_seq_pkg.sv
// addsub32_seq_pkg: shared ALU constants for the two-cycle 32-bit add/subtract sequencer.
package addsub32_seq_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
endpackage

// File: rtl/adder_subtractor_16bits.sv
// adder_subtractor_16bits: shared 16-bit adder; subtraction is set up by the caller (inverted b, ci=1).
module adder_subtractor_16bits (
    input  logic        ci,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {16'd0, ci};
endmodule

// File: rtl/addsub32_seq.sv
// addsub32_seq: 32-bit add/subtract over two passes of the shared 16-bit adder, low half first.
module addsub32_seq
    import addsub32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_carry,
    output logic        out_ovf
);
    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] a_q, b_q, sum_q;
    logic [HALF_W-1:0] lo_q, add_a, add_b, add_s;
    logic              sub_q, c_lo_q, carry_q, ovf_q, add_ci, add_co, hi;

    assign hi     = state_q == S_HI;
    assign add_a  = hi ? a_q[WORD_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign add_b  = (hi ? b_q[WORD_W-1:HALF_W] : b_q[HALF_W-1:0]) ^ {HALF_W{sub_q}};
    assign add_ci = hi ? c_lo_q : sub_q;

    adder_subtractor_16bits u_add (
        .ci(add_ci),
        .a (add_a),
        .b (add_b),
        .s (add_s),
        .co(add_co)
    );

    always_comb begin
        state_d = state_q == S_IDLE ? (in_valid ? S_LO : S_IDLE) :
                  state_q == S_LO   ? S_HI :
                  state_q == S_HI   ? S_DONE :
                  (out_ready ? S_IDLE : S_DONE);
    end

    // Low half is parked in lo_q so out_sum only moves on the HI->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            lo_q    <= '0;
            c_lo_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sub_q <= in_sub;
            end
            if (state_q == S_LO) begin
                lo_q   <= add_s;
                c_lo_q <= add_co;
            end
            if (hi) begin
                sum_q   <= {add_s, lo_q};
                carry_q <= add_co;
                ovf_q   <= (a_q[WORD_W-1] == (b_q[WORD_W-1] ^ sub_q)) & (add_s[HALF_W-1] != a_q[WORD_W-1]);
            end
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
endmodule
